// File: rtl/emu_time_pkg.sv
// Shared types and default sizes for the emulation time-step scheduler.
//   emu_cmd_t   : host command encoding carried on ctrl_mode
//   emu_state_t : scheduler state (HALT stalls time advance)
package emu_time_pkg;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned DT_WIDTH_DEF   = 27;
  localparam int unsigned TIME_WIDTH_DEF = 39;

  typedef enum logic [1:0] {
    STOP      = 2'd0,
    RUN       = 2'd1,
    STEP_N    = 2'd2,
    RUN_UNTIL = 2'd3
  } emu_cmd_t;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_UNTIL = 2'd3
  } emu_state_t;

endpackage

// File: rtl/emu_min_tree.sv
// Combinational minimum reduction over N_REQ packed dt requests.
//   req_i     : requester i at [i*DT_WIDTH +: DT_WIDTH]
//   min_o     : smallest request
//   eq_mask_o : bit i set when request i equals the minimum (ties set several bits)
module emu_min_tree #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DT_WIDTH = 27
) (
  input  logic [N_REQ*DT_WIDTH-1:0] req_i,
  output logic [DT_WIDTH-1:0]       min_o,
  output logic [N_REQ-1:0]          eq_mask_o
);

  // Leaves padded to a power of two; pad leaves hold all-ones so they never win.
  localparam int unsigned LEVELS = (N_REQ > 1) ? $clog2(N_REQ) : 0;
  localparam int unsigned LEAVES = 1 << LEVELS;
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  logic [DT_WIDTH-1:0] node [NODES];

  // Heap-ordered tree: node k has children 2k+1 and 2k+2, root at 0.
  always_comb begin
    for (int k = 0; k < int'(NODES); k++) begin
      node[k] = '1;
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      node[int'(LEAVES) - 1 + i] = req_i[i*DT_WIDTH +: DT_WIDTH];
    end
    for (int k = int'(LEAVES) - 2; k >= 0; k--) begin
      node[k] = (node[2*k+1] <= node[2*k+2]) ? node[2*k+1] : node[2*k+2];
    end
  end

  assign min_o = node[0];

  always_comb begin
    eq_mask_o = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      eq_mask_o[i] = (req_i[i*DT_WIDTH +: DT_WIDTH] == node[0]);
    end
  end

endmodule

// File: rtl/emu_time_mgr.sv
// Emulation time-step scheduler: each emu_clk edge advances emu_time by the
// smallest clipped dt request, gated by a host STOP/RUN/STEP_N/RUN_UNTIL command.
//   emu_clk, emu_rst        : clock, synchronous active-high reset
//   ctrl_valid/mode/data    : one-cycle command strobe, command, count or target time
//   dt_req                  : packed per-requester dt requests
//   emu_dt, emu_time        : dt applied at the last edge, accumulated time
//   step_en                 : requesters that owned the last step
//   emu_stall, time_ovf     : halted flag, sticky wrap flag
module emu_time_mgr
  import emu_time_pkg::*;
#(
  parameter int unsigned         N_REQ      = N_REQ_DEF,
  parameter int unsigned         DT_WIDTH   = DT_WIDTH_DEF,
  parameter int unsigned         TIME_WIDTH = TIME_WIDTH_DEF,
  parameter logic [DT_WIDTH-1:0] DT_MAX     = '1
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst,
  input  logic                      ctrl_valid,
  input  logic [1:0]                ctrl_mode,
  input  logic [TIME_WIDTH-1:0]     ctrl_data,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic [N_REQ-1:0]          step_en,
  output logic                      emu_stall,
  output logic                      time_ovf
);

  localparam int unsigned TW1 = TIME_WIDTH + 1;

  emu_state_t             state_q, state_d;
  logic [TIME_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TIME_WIDTH-1:0]  target_q, target_d;
  logic [TIME_WIDTH-1:0]  time_q, time_d;
  logic [DT_WIDTH-1:0]    dt_q, dt_d;
  logic [N_REQ-1:0]       en_q, en_d;
  logic                   stall_q, stall_d;
  logic                   ovf_q, ovf_d;

  logic [N_REQ*DT_WIDTH-1:0] req_clip_c;
  logic [DT_WIDTH-1:0]       min_c;
  logic [N_REQ-1:0]          eq_mask_c;
  logic [TIME_WIDTH-1:0]     remain_c;
  logic [DT_WIDTH-1:0]       dt_step_c;
  logic [TW1-1:0]            sum_c;

  // Clip every request to DT_MAX before the minimum search.
  always_comb begin
    req_clip_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_clip_c[i*DT_WIDTH +: DT_WIDTH] =
        (dt_req[i*DT_WIDTH +: DT_WIDTH] > DT_MAX) ? DT_MAX : dt_req[i*DT_WIDTH +: DT_WIDTH];
    end
  end

  emu_min_tree #(
    .N_REQ    (N_REQ),
    .DT_WIDTH (DT_WIDTH)
  ) u_min_tree (
    .req_i     (req_clip_c),
    .min_o     (min_c),
    .eq_mask_o (eq_mask_c)
  );

  // In RUN_UNTIL the step is clamped so time lands exactly on the target.
  always_comb begin
    remain_c  = target_q - time_q;
    dt_step_c = min_c;
    if ((state_q == S_UNTIL) && (remain_c < TIME_WIDTH'(min_c))) begin
      dt_step_c = DT_WIDTH'(remain_c);
    end
    sum_c = TW1'(time_q) + TW1'(dt_step_c);
  end

  // Next state and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    time_d   = time_q;
    dt_d     = '0;
    en_d     = '0;
    ovf_d    = ovf_q;

    if (ctrl_valid) begin
      // Command edge only loads the command; stepping starts next edge.
      unique case (emu_cmd_t'(ctrl_mode))
        STOP: state_d = HALT;
        RUN:  state_d = S_RUN;
        STEP_N: begin
          cnt_d   = ctrl_data;
          state_d = (ctrl_data == '0) ? HALT : S_STEP;
        end
        RUN_UNTIL: begin
          target_d = ctrl_data;
          state_d  = (ctrl_data <= time_q) ? HALT : S_UNTIL;
        end
        default: state_d = HALT;
      endcase
    end else if (state_q != HALT) begin
      time_d = sum_c[TIME_WIDTH-1:0];
      ovf_d  = ovf_q | sum_c[TIME_WIDTH];
      dt_d   = dt_step_c;
      en_d   = (dt_step_c == min_c) ? eq_mask_c : '0;
      if (state_q == S_STEP) begin
        cnt_d = cnt_q - TIME_WIDTH'(1);
        if (cnt_q == TIME_WIDTH'(1)) begin
          state_d = HALT;
        end
      end
      if ((state_q == S_UNTIL) && (sum_c[TIME_WIDTH-1:0] == target_q)) begin
        state_d = HALT;
      end
    end

    stall_d = (state_d == HALT);
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q  <= HALT;
      cnt_q    <= '0;
      target_q <= '0;
      time_q   <= '0;
      dt_q     <= '0;
      en_q     <= '0;
      stall_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      time_q   <= time_d;
      dt_q     <= dt_d;
      en_q     <= en_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  assign emu_dt    = dt_q;
  assign emu_time  = time_q;
  assign step_en   = en_q;
  assign emu_stall = stall_q;
  assign time_ovf  = ovf_q;

endmodule
